// File: rtl/tbec_pkg.sv
// Shared types and default widths for the TBEC memory scrubber.
package tbec_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_LAT = 1;
    localparam int CNT_W      = 16;

    // Error code reported by the decoder alongside each read word.
    typedef enum logic [1:0] {
        ERR_CLEAN  = 2'b00,
        ERR_CORR   = 2'b01,
        ERR_UNCORR = 2'b10,
        ERR_MULTI  = 2'b11
    } err_code_e;

    // Scrubber sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_CHK  = 3'd3,
        ST_WB   = 3'd4,
        ST_NXT  = 3'd5
    } scrub_state_e;

endpackage

// File: rtl/tbec_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module tbec_sat_counter
    import tbec_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear has priority over increment; increments stop once the count is full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tbec_scrubber.sv
// Background scrubber for a TBEC-protected memory: walks every address,
// writes back single-bit corrected words, and logs uncorrectable locations.
// The host shares the memory port and wins it whenever the scrubber is in
// IDLE or RD, so scrubbing never blocks host traffic for long.
module tbec_scrubber
    import tbec_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_start,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_err,
    output logic              scrub_busy,
    output logic              scrub_done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic [ADDR_W-1:0] last_uncorr_addr,
    output logic              uncorr_flag
);

    // WAIT spends RD_LAT cycles in total (wait_cnt counts down from RD_LAT-1),
    // so the read address is held long enough for any read latency.
    localparam int              WC_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(RD_LAT - 1);

    scrub_state_e      state;
    logic [ADDR_W-1:0] scrub_addr;
    logic [WC_W-1:0]   wait_cnt;
    logic [DATA_W-1:0] wb_data;

    logic              pass_clr;
    logic              corr_inc;
    logic              uncorr_inc;

    // Start of a pass clears the per-pass statistics; CHK classifies each word.
    assign pass_clr   = (state == ST_IDLE) && scrub_start;
    assign corr_inc   = (state == ST_CHK) && (mem_err == ERR_CORR);
    assign uncorr_inc = (state == ST_CHK) && mem_err[1];

    assign scrub_busy = (state != ST_IDLE);
    assign host_gnt   = host_req && ((state == ST_IDLE) || (state == ST_RD));

    // Memory port mux: host when granted, write-back word in WB, otherwise a
    // quiet read of the current scrub address.
    always_comb begin
        mem_addr  = scrub_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end else if (state == ST_WB) begin
            mem_we    = 1'b1;
            mem_wdata = wb_data;
        end
    end

    // Scrub sequencer: read, wait out latency, check, optionally write back, advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            scrub_addr       <= '0;
            wait_cnt         <= '0;
            wb_data          <= '0;
            scrub_done       <= 1'b0;
            last_uncorr_addr <= '0;
            uncorr_flag      <= 1'b0;
        end else begin
            scrub_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scrub_start) begin
                        scrub_addr       <= '0;
                        last_uncorr_addr <= '0;
                        uncorr_flag      <= 1'b0;
                        state            <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (!host_req) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_CHK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_CHK: begin
                    case (mem_err)
                        ERR_CLEAN: begin
                            state <= ST_NXT;
                        end
                        ERR_CORR: begin
                            wb_data <= mem_rdata;
                            state   <= ST_WB;
                        end
                        default: begin
                            last_uncorr_addr <= scrub_addr;
                            uncorr_flag      <= 1'b1;
                            state            <= ST_NXT;
                        end
                    endcase
                end
                ST_WB: begin
                    state <= ST_NXT;
                end
                ST_NXT: begin
                    if (&scrub_addr) begin
                        scrub_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        scrub_addr <= scrub_addr + 1'b1;
                        state      <= ST_RD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    tbec_sat_counter #(.W(CNT_W)) u_corr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pass_clr),
        .inc (corr_inc),
        .cnt (corr_cnt)
    );

    tbec_sat_counter #(.W(CNT_W)) u_uncorr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pass_clr),
        .inc (uncorr_inc),
        .cnt (uncorr_cnt)
    );

endmodule

// File: tb/tb_tbec_scrubber.sv
// Directed bench for tbec_scrubber: two instances (RD_LAT=1 and RD_LAT=2),
// each attached to a small behavioural memory returning {addr, ~addr} with
// an injectable per-address error code that a write clears.
module tb_tbec_scrubber;
    import tbec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance 1 (RD_LAT = 1)
    logic        start1, host_req, host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        gnt1, we1, busy1, done1, flag1;
    logic [7:0]  addr1, last1;
    logic [15:0] wdata1, corr1, unc1;
    logic [15:0] rdata1 = '0;
    logic [1:0]  err1   = '0;

    // Instance 2 (RD_LAT = 2)
    logic        start2, h2_req, h2_we;
    logic [7:0]  h2_addr;
    logic [15:0] h2_wdata;
    logic        gnt2, we2, busy2, done2, flag2;
    logic [7:0]  addr2, last2;
    logic [15:0] wdata2, corr2, unc2;
    logic [15:0] p1d2 = '0, rdata2 = '0;
    logic [1:0]  p1e2 = '0, err2   = '0;

    logic [1:0]  errc1 [256] = '{default: 2'b00};
    logic [1:0]  errc2 [256] = '{default: 2'b00};

    logic        inj_en, inj_sel, seq_clr;
    logic [7:0]  inj_addr;
    logic [1:0]  inj_code;

    int          n_reads = 0, skips = 0, wr_count = 0, wr2_count = 0;
    logic [7:0]  last_seen = 8'hFF, wr_addr = '0, wr2_addr = '0;
    logic [15:0] wr_data = '0, wr2_data = '0;

    int checks = 0;
    int failures = 0;

    tbec_scrubber #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .scrub_start(start1),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(gnt1), .mem_addr(addr1), .mem_we(we1), .mem_wdata(wdata1),
        .mem_rdata(rdata1), .mem_err(err1), .scrub_busy(busy1), .scrub_done(done1),
        .corr_cnt(corr1), .uncorr_cnt(unc1), .last_uncorr_addr(last1), .uncorr_flag(flag1)
    );

    tbec_scrubber #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .scrub_start(start2),
        .host_req(h2_req), .host_we(h2_we), .host_addr(h2_addr), .host_wdata(h2_wdata),
        .host_gnt(gnt2), .mem_addr(addr2), .mem_we(we2), .mem_wdata(wdata2),
        .mem_rdata(rdata2), .mem_err(err2), .scrub_busy(busy2), .scrub_done(done2),
        .corr_cnt(corr2), .uncorr_cnt(unc2), .last_uncorr_addr(last2), .uncorr_flag(flag2)
    );

    function automatic logic [15:0] true_word(input logic [7:0] a);
        return {a, ~a};
    endfunction

    // Memory 1: one-cycle read, write clears the error code; also tracks the
    // scrub address sequence and logs scrubber writes.
    always @(posedge clk) begin
        rdata1 <= true_word(addr1);
        err1   <= errc1[addr1];
        if (we1) errc1[addr1] <= 2'b00;
        if (inj_en && !inj_sel) errc1[inj_addr] <= inj_code;
        if (seq_clr) begin
            last_seen <= 8'hFF;
            n_reads   <= 0;
            skips     <= 0;
            wr_count  <= 0;
        end else begin
            if (busy1 && !gnt1 && !we1 && addr1 != last_seen) begin
                if (addr1 != last_seen + 8'd1) skips <= skips + 1;
                n_reads   <= n_reads + 1;
                last_seen <= addr1;
            end
            if (we1 && !gnt1) begin
                wr_count <= wr_count + 1;
                wr_addr  <= addr1;
                wr_data  <= wdata1;
            end
        end
    end

    // Memory 2: two-cycle read pipeline.
    always @(posedge clk) begin
        p1d2   <= true_word(addr2);
        p1e2   <= errc2[addr2];
        rdata2 <= p1d2;
        err2   <= p1e2;
        if (we2) begin
            errc2[addr2] <= 2'b00;
            wr2_count    <= wr2_count + 1;
            wr2_addr     <= addr2;
            wr2_data     <= wdata2;
        end
        if (inj_en && inj_sel) errc2[inj_addr] <= inj_code;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic inject(input logic sel, input logic [7:0] a, input logic [1:0] c);
        @(negedge clk);
        inj_en = 1'b1; inj_sel = sel; inj_addr = a; inj_code = c;
        @(negedge clk);
        inj_en = 1'b0;
    endtask

    task automatic start_pass();
        @(negedge clk);
        start1 = 1'b1; seq_clr = 1'b1;
        @(negedge clk);
        start1 = 1'b0; seq_clr = 1'b0;
    endtask

    task automatic wait_done1(input string tag);
        int n = 0;
        while (done1 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done1}, 32'd1);
    endtask

    task automatic wait_addr1(input string tag, input logic [7:0] a);
        int n = 0;
        while (!(busy1 && !gnt1 && addr1 == a) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {24'd0, addr1}, {24'd0, a});
    endtask

    initial begin
        int n;
        rst = 1'b0;
        start1 = 0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        start2 = 0; h2_req = 0; h2_we = 0; h2_addr = '0; h2_wdata = '0;
        inj_en = 0; inj_sel = 0; inj_addr = '0; inj_code = '0; seq_clr = 0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy", {31'd0, busy1}, 0);
        check("rst_done", {31'd0, done1}, 0);
        check("rst_we", {31'd0, we1}, 0);
        check("rst_wdata", {16'd0, wdata1}, 0);
        check("rst_corr", {16'd0, corr1}, 0);
        check("rst_unc", {16'd0, unc1}, 0);
        check("rst_flag", {31'd0, flag1}, 0);
        check("rst_last", {24'd0, last1}, 0);
        check("rst_addr", {24'd0, addr1}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Clean pass, started in the same IDLE cycle as a host read
        @(negedge clk);
        start1 = 1'b1; seq_clr = 1'b1; host_req = 1'b1; host_addr = 8'h33;
        #1;
        check("idle_gnt", {31'd0, gnt1}, 1);
        check("idle_host_addr", {24'd0, addr1}, 32'h33);
        @(negedge clk);
        start1 = 1'b0; seq_clr = 1'b0; host_req = 1'b0;
        check("start_busy", {31'd0, busy1}, 1);
        wait_done1("clean_done");
        check("clean_reads", n_reads, 256);
        check("clean_skips", skips, 0);
        check("clean_lastaddr", {24'd0, last_seen}, 32'hFF);
        check("clean_writes", wr_count, 0);
        check("clean_corr", {16'd0, corr1}, 0);
        check("clean_unc", {16'd0, unc1}, 0);
        @(negedge clk);
        check("done_pulse", {31'd0, done1}, 0);
        check("idle_busy", {31'd0, busy1}, 0);

        // Single-bit error at 0x12, host stall at 0x40, ignored start at 0x80
        inject(1'b0, 8'h12, 2'b01);
        start_pass();
        wait_addr1("reach_40", 8'h40);
        host_req = 1'b1; host_addr = 8'hA5;
        #1;
        check("host_gnt_c0", {31'd0, gnt1}, 1);
        check("host_addr_c0", {24'd0, addr1}, 32'hA5);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("host_gnt_hold", {31'd0, gnt1}, 1);
        end
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check("host_release_gnt", {31'd0, gnt1}, 0);
        check("resume_addr", {24'd0, addr1}, 32'h40);
        wait_addr1("reach_80", 8'h80);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1("corr_done");
        check("corr_cnt", {16'd0, corr1}, 1);
        check("corr_unc", {16'd0, unc1}, 0);
        check("corr_writes", wr_count, 1);
        check("corr_wr_addr", {24'd0, wr_addr}, 32'h12);
        check("corr_wr_data", {16'd0, wr_data}, {16'd0, true_word(8'h12)});
        check("corr_reads", n_reads, 256);
        check("corr_skips", skips, 0);
        check("corr_cleared", {30'd0, errc1[8'h12]}, 0);

        // Second pass after write-back finds nothing
        start_pass();
        wait_done1("pass2_done");
        check("pass2_corr", {16'd0, corr1}, 0);
        check("pass2_writes", wr_count, 0);

        // Double-bit error at 0x80
        inject(1'b0, 8'h80, 2'b10);
        start_pass();
        wait_done1("unc_done");
        check("unc_cnt", {16'd0, unc1}, 1);
        check("unc_corr", {16'd0, corr1}, 0);
        check("unc_last", {24'd0, last1}, 32'h80);
        check("unc_flag", {31'd0, flag1}, 1);
        check("unc_writes", wr_count, 0);
        repeat (10) @(negedge clk);
        check("unc_flag_sticky", {31'd0, flag1}, 1);

        // Code 11 at 0x80 plus a correctable word at 0x90, reset during its write-back
        inject(1'b0, 8'h80, 2'b11);
        inject(1'b0, 8'h90, 2'b01);
        start_pass();
        check("start_clears_flag", {31'd0, flag1}, 0);
        check("start_clears_unc", {16'd0, unc1}, 0);
        n = 0;
        while (!(we1 && !gnt1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wb_seen", {31'd0, we1}, 1);
        check("wb_addr", {24'd0, addr1}, 32'h90);
        check("wb_data", {16'd0, wdata1}, {16'd0, true_word(8'h90)});
        check("pre_rst_unc", {16'd0, unc1}, 1);
        check("pre_rst_last", {24'd0, last1}, 32'h80);
        #1 rst = 1'b0;
        #1;
        check("rstwb_we", {31'd0, we1}, 0);
        check("rstwb_wdata", {16'd0, wdata1}, 0);
        check("rstwb_busy", {31'd0, busy1}, 0);
        check("rstwb_corr", {16'd0, corr1}, 0);
        check("rstwb_unc", {16'd0, unc1}, 0);
        check("rstwb_flag", {31'd0, flag1}, 0);
        check("rstwb_last", {24'd0, last1}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rstwb_no_write", wr_count, 0);
        check("rstwb_still_bad", {30'd0, errc1[8'h90]}, 32'd1);
        start_pass();
        check("restart_addr", {24'd0, addr1}, 0);
        wait_done1("restart_done");
        check("restart_reads", n_reads, 256);
        check("restart_skips", skips, 0);
        check("restart_corr", {16'd0, corr1}, 1);
        check("restart_wr_addr", {24'd0, wr_addr}, 32'h90);
        check("restart_unc11", {16'd0, unc1}, 1);

        // RD_LAT = 2 instance, single-bit error at the final address
        inject(1'b1, 8'hFF, 2'b01);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("lat2_done", {31'd0, done2}, 1);
        check("lat2_writes", wr2_count, 1);
        check("lat2_wr_addr", {24'd0, wr2_addr}, 32'hFF);
        check("lat2_wr_data", {16'd0, wr2_data}, 32'hFF00);
        check("lat2_corr", {16'd0, corr2}, 1);
        check("lat2_unc", {16'd0, unc2}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tbec_scrubber.md
TBEC_SCRUBBER -- requirements
Module: tbec_scrubber

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width; scrub range is 0 to 2^ADDR_W-1.
REQ-002 Parameter DATA_W, default 16, unencoded data width.
REQ-003 Parameter RD_LAT, default 1, cycles from address presented to valid mem_rdata/mem_err.
REQ-004 Ports: clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 scrub_start  in  1  one-cycle pulse that starts a full pass; ignored while busy.
REQ-007 host_req, host_we  in  1 each  host access request and write enable.
REQ-008 host_addr  in  ADDR_W; host_wdata  in  DATA_W  host access address and write data.
REQ-009 host_gnt  out  1  host signals drive the memory port this cycle.
REQ-010 mem_addr  out  ADDR_W; mem_we  out  1; mem_wdata  out  DATA_W  feed the tbec_full address, write-enable and data_in.
REQ-011 mem_rdata  in  DATA_W; mem_err  in  2  decoded data and error code from tbec_full.
REQ-012 scrub_busy  out  1; scrub_done  out  1  one-cycle pulse at pass end.
REQ-013 corr_cnt, uncorr_cnt  out  16 each  saturating error counters for the current pass.
REQ-014 last_uncorr_addr  out  ADDR_W; uncorr_flag  out  1  sticky uncorrectable indication.

Function
REQ-015 Error codes: 00 clean, 01 corrected, 10 uncorrectable, 11 handled as uncorrectable.
REQ-016 FSM states: IDLE, RD, WAIT, CHK, WB, NXT.
REQ-017 IDLE: scrub_start -> clear both counters, uncorr_flag and last_uncorr_addr; set scrub_addr=0; go to RD.
REQ-018 RD: drive mem_addr=scrub_addr with mem_we=0; if host_req is high, stall in RD; otherwise go to WAIT.
REQ-019 WAIT: hold mem_addr for RD_LAT-1 cycles, counted by a down-counter; with RD_LAT=1, pass through WAIT in one cycle.
REQ-020 CHK: sample mem_rdata/mem_err. On 00 go to NXT. On 01 capture mem_rdata, increment corr_cnt, go to WB. On 10/11 increment uncorr_cnt, load last_uncorr_addr, set uncorr_flag, go to NXT; no write-back occurs.
REQ-021 WB: drive mem_we=1 for exactly one cycle, with mem_addr=scrub_addr and mem_wdata=the captured word; host_gnt=0 in this cycle; go to NXT.
REQ-022 NXT: if scrub_addr equals all-ones, pulse scrub_done and go to IDLE; otherwise increment scrub_addr and go to RD.
REQ-023 host_gnt = host_req when the state is IDLE or RD; 0 in all other states.
REQ-024 When host_gnt=1, mem_addr/mem_we/mem_wdata equal the host inputs combinationally; the host sees read data per RD_LAT.
REQ-025 Counters saturate at 16'hFFFF and do not wrap.
REQ-026 scrub_busy=1 in every state except IDLE.
REQ-027 When not host-granted and not in WB: mem_we=0 and mem_wdata=0.
REQ-028 scrub_start while busy has no effect; scrub_start and host_req in the same IDLE cycle: host is granted, and the FSM still enters RD.

Reset
REQ-029 While rst=0: state=IDLE, scrub_addr=0, all counters, flags, last_uncorr_addr and captured data = 0, scrub_done=0, mem_we=0.
REQ-030 Reset asserted mid-pass abandons the pass; a WB in progress is cut off, and no partial write occurs after rst rises.

Structure
REQ-031 Package tbec_pkg holds the error-code enum, the FSM state enum and the default widths.
REQ-032 One sub-module, tbec_sat_counter (16-bit saturating with clear), is instantiated twice.
REQ-033 Top-level integration wraps tbec_scrubber and tbec_full; no memory array inside the scrubber.

Verification
REQ-034 Clean memory, start -> 256 reads, no mem_we, scrub_done 1 cycle after the address FF check, both counters 0.
REQ-035 Single-bit flip at addr 0x12 -> exactly one write to 0x12 with the corrected word, corr_cnt=1; a second pass gives corr_cnt=0.
REQ-036 Double-bit error at 0x80 -> no write, uncorr_cnt=1, last_uncorr_addr=0x80, uncorr_flag=1 until the next start.
REQ-037 host_req held 5 cycles while in RD at addr 0x40 -> host_gnt for those 5 cycles, scrubber resumes at 0x40, no address skipped.
REQ-038 rst pulsed low during WB -> mem_we=0 immediately, outputs at reset values, a new start scans from 0.
REQ-039 RD_LAT=2 build, single-bit flip at 0xFF -> correct sampling, write-back, then scrub_done.
